// File: rtl/axi_ext_mem_pkg.sv
// rtl/axi_ext_mem_pkg.sv - shared response codes, queue entry types and time-base helper
package axi_ext_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Entry fields are sized for the widest supported ID and memory index.
  localparam int ID_W  = 8;
  localparam int IDX_W = 16;

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [7:0]       tick_t;

  typedef struct packed {
    id_t   id;
    idx_t  widx;
    logic  in_range;
    tick_t due;
  } ar_ent_t;

  typedef struct packed {
    id_t  id;
    idx_t widx;
    logic in_range;
  } aw_ent_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
  } w_ent_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    tick_t      due;
  } b_ent_t;

  // Due test on a wrapping 8-bit counter: reached when now is within 128 ticks past due.
  function automatic logic tick_reached(input tick_t now, input tick_t due);
    tick_t diff;
    diff = now - due;
    return ~diff[7];
  endfunction

endpackage

// File: rtl/axi_mem_sync_fifo.sv
// rtl/axi_mem_sync_fifo.sv - synchronous FIFO with registered pointers and head read-out
module axi_mem_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      store[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axi_ext_mem_slave.sv
// rtl/axi_ext_mem_slave.sv - AXI4 single-beat 64-bit memory slave with programmable read/write latency
module axi_ext_mem_slave
  import axi_ext_mem_pkg::*;
#(
  parameter int          ID_WIDTH   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MEM_AW     = 16,
  parameter int          RD_LATENCY = 4,
  parameter int          WR_LATENCY = 2,
  parameter int          QDEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ID_WIDTH-1:0] s_arid,
  input  logic [31:0]         s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [63:0]         s_rdata,
  output logic [ID_WIDTH-1:0] s_rid,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ID_WIDTH-1:0] s_awid,
  input  logic [31:0]         s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [63:0]         s_wdata,
  input  logic [7:0]          s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [ID_WIDTH-1:0] s_bid,
  output logic [1:0]          s_bresp
);

  localparam tick_t       RD_DLY    = tick_t'(RD_LATENCY - 1);
  localparam tick_t       WR_DLY    = tick_t'(WR_LATENCY - 1);
  localparam logic [32:0] MEM_BYTES = 33'd8 << MEM_AW;

  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ({1'b0, addr - BASE_ADDR} < MEM_BYTES);
  endfunction

  function automatic idx_t word_idx(input logic [31:0] addr);
    return idx_t'((addr - BASE_ADDR) >> 3);
  endfunction

  tick_t   now;
  ar_ent_t ar_in, ar_head;
  aw_ent_t aw_in, aw_head;
  w_ent_t  w_in, w_head;
  b_ent_t  b_in, b_head;
  logic    ar_full, ar_empty, aw_full, aw_empty, w_full, w_empty, b_full, b_empty;
  logic    r_pop, b_pop, commit;

  logic [63:0] mem [1 << MEM_AW];

  always_ff @(posedge clk) begin
    if (!reset_l) now <= '0;
    else          now <= now + 8'd1;
  end

  assign s_arready = ~ar_full;
  assign s_awready = ~aw_full;
  assign s_wready  = ~w_full;
  assign s_rlast   = s_rvalid;

  always_comb begin
    ar_in          = '0;
    ar_in.id       = id_t'(s_arid);
    ar_in.widx     = word_idx(s_araddr);
    ar_in.in_range = addr_in_range(s_araddr);
    ar_in.due      = now + RD_DLY;
    aw_in          = '0;
    aw_in.id       = id_t'(s_awid);
    aw_in.widx     = word_idx(s_awaddr);
    aw_in.in_range = addr_in_range(s_awaddr);
    w_in.data      = s_wdata;
    w_in.strb      = s_wstrb;
    b_in           = '0;
    b_in.id        = aw_head.id;
    b_in.resp      = aw_head.in_range ? RESP_OKAY : RESP_SLVERR;
    b_in.due       = now + WR_DLY;
  end

  // A head leaves its queue only once due and the output slot is free or draining.
  assign r_pop  = ~ar_empty & tick_reached(now, ar_head.due) & (~s_rvalid | s_rready);
  assign b_pop  = ~b_empty & tick_reached(now, b_head.due) & (~s_bvalid | s_bready);
  assign commit = ~aw_empty & ~w_empty & ~b_full;

  axi_mem_sync_fifo #(.WIDTH($bits(ar_ent_t)), .DEPTH(QDEPTH)) u_arq (
    .clk(clk), .reset_l(reset_l), .push(s_arvalid), .push_data(ar_in), .pop(r_pop),
    .full(ar_full), .empty(ar_empty), .head(ar_head)
  );

  axi_mem_sync_fifo #(.WIDTH($bits(aw_ent_t)), .DEPTH(QDEPTH)) u_awq (
    .clk(clk), .reset_l(reset_l), .push(s_awvalid), .push_data(aw_in), .pop(commit),
    .full(aw_full), .empty(aw_empty), .head(aw_head)
  );

  axi_mem_sync_fifo #(.WIDTH($bits(w_ent_t)), .DEPTH(QDEPTH)) u_wq (
    .clk(clk), .reset_l(reset_l), .push(s_wvalid), .push_data(w_in), .pop(commit),
    .full(w_full), .empty(w_empty), .head(w_head)
  );

  axi_mem_sync_fifo #(.WIDTH($bits(b_ent_t)), .DEPTH(QDEPTH)) u_bq (
    .clk(clk), .reset_l(reset_l), .push(commit), .push_data(b_in), .pop(b_pop),
    .full(b_full), .empty(b_empty), .head(b_head)
  );

  // Non-blocking update means a same-cycle read of the committed word still sees old data.
  always_ff @(posedge clk) begin
    if (reset_l && commit && aw_head.in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (w_head.strb[i])
          mem[aw_head.widx[MEM_AW-1:0]][8*i +: 8] <= w_head.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rid    <= '0;
      s_rresp  <= '0;
    end else if (r_pop) begin
      s_rvalid <= 1'b1;
      s_rdata  <= ar_head.in_range ? mem[ar_head.widx[MEM_AW-1:0]] : 64'd0;
      s_rid    <= ar_head.id[ID_WIDTH-1:0];
      s_rresp  <= ar_head.in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      s_bvalid <= 1'b0;
      s_bid    <= '0;
      s_bresp  <= '0;
    end else if (b_pop) begin
      s_bvalid <= 1'b1;
      s_bid    <= b_head.id[ID_WIDTH-1:0];
      s_bresp  <= b_head.resp;
    end else if (s_bready) begin
      s_bvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_ext_mem_slave.sv
// tb/tb_axi_ext_mem_slave.sv - directed self-checking bench for axi_ext_mem_slave
module tb_axi_ext_mem_slave;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        s_arvalid = 1'b0, s_arready;
  logic [7:0]  s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic        s_rvalid, s_rready = 1'b1;
  logic [63:0] s_rdata;
  logic [7:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_awvalid = 1'b0, s_awready;
  logic [7:0]  s_awid = '0;
  logic [31:0] s_awaddr = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_bvalid, s_bready = 1'b1;
  logic [7:0]  s_bid;
  logic [1:0]  s_bresp;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axi_ext_mem_slave #(
    .ID_WIDTH(8), .BASE_ADDR(BASE), .MEM_AW(16),
    .RD_LATENCY(4), .WR_LATENCY(2), .QDEPTH(4)
  ) dut (
    .clk(clk), .reset_l(reset_l),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
  );

  // Stimulus helpers: start and end just after a rising edge, readies assumed free.
  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output logic [7:0] bid, output logic [1:0] bresp,
                          output int lat);
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr;
    s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    lat = -1; bid = '0; bresp = '0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (s_bvalid) begin lat = k; bid = s_bid; bresp = s_bresp; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, output logic [63:0] data,
                         output logic [7:0] rid, output logic [1:0] rresp, output logic rlast,
                         output int lat);
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    lat = -1; data = '0; rid = '0; rresp = '0; rlast = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (s_rvalid) begin lat = k; data = s_rdata; rid = s_rid; rresp = s_rresp; rlast = s_rlast; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
    @(negedge clk);
    checks++; if (s_arready !== 1'b1) $display("FAIL reset_arready got %b exp 1", s_arready); else passed++;
    checks++; if (s_awready !== 1'b1) $display("FAIL reset_awready got %b exp 1", s_awready); else passed++;
    checks++; if (s_wready !== 1'b1) $display("FAIL reset_wready got %b exp 1", s_wready); else passed++;
    checks++; if (s_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b exp 0", s_rvalid); else passed++;
    checks++; if (s_bvalid !== 1'b0) $display("FAIL reset_bvalid got %b exp 0", s_bvalid); else passed++;
    checks++; if (s_rdata !== 64'd0) $display("FAIL reset_rdata got %h exp 0", s_rdata); else passed++;
    checks++; if (s_rid !== 8'd0) $display("FAIL reset_rid got %h exp 0", s_rid); else passed++;
    checks++; if (s_rresp !== 2'd0) $display("FAIL reset_rresp got %b exp 00", s_rresp); else passed++;
    checks++; if (s_bid !== 8'd0) $display("FAIL reset_bid got %h exp 0", s_bid); else passed++;
    checks++; if (s_bresp !== 2'd0) $display("FAIL reset_bresp got %b exp 00", s_bresp); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    logic [7:0] bid, rid; logic [1:0] br, rr; logic rl; logic [63:0] d; int lat;
    do_write(8'd1, BASE + 32'h80, 64'h1122_3344_5566_7788, 8'hFF, bid, br, lat);
    checks++; if (br !== 2'b00) $display("FAIL rd_preload_bresp got %b exp 00", br); else passed++;
    do_read(8'd5, BASE + 32'h80, d, rid, rr, rl, lat);
    checks++; if (lat !== 4) $display("FAIL rd_latency got %0d exp 4", lat); else passed++;
    checks++; if (d !== 64'h1122_3344_5566_7788) $display("FAIL rd_data got %h exp 1122334455667788", d); else passed++;
    checks++; if (rid !== 8'd5) $display("FAIL rd_rid got %0d exp 5", rid); else passed++;
    checks++; if (rr !== 2'b00) $display("FAIL rd_rresp got %b exp 00", rr); else passed++;
    checks++; if (rl !== 1'b1) $display("FAIL rd_rlast got %b exp 1", rl); else passed++;
  endtask

  task automatic test_write_strobe();
    logic [7:0] bid, rid; logic [1:0] br, rr; logic rl; logic [63:0] d; int lat;
    do_write(8'd2, BASE + 32'h8, 64'd0, 8'hFF, bid, br, lat);
    do_write(8'd3, BASE + 32'h8, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, bid, br, lat);
    checks++; if (lat !== 3) $display("FAIL wr_b_latency got %0d exp 3", lat); else passed++;
    checks++; if (bid !== 8'd3) $display("FAIL wr_bid got %0d exp 3", bid); else passed++;
    checks++; if (br !== 2'b00) $display("FAIL wr_bresp got %b exp 00", br); else passed++;
    do_read(8'd7, BASE + 32'h8, d, rid, rr, rl, lat);
    checks++; if (d !== 64'h0000_0000_AAAA_AAAA) $display("FAIL wr_strb_low got %h exp 00000000aaaaaaaa", d); else passed++;
    do_write(8'd4, BASE + 32'h8, 64'h5555_5555_5555_5555, 8'hA0, bid, br, lat);
    do_read(8'd8, BASE + 32'h8, d, rid, rr, rl, lat);
    checks++; if (d !== 64'h5500_5500_AAAA_AAAA) $display("FAIL wr_strb_sparse got %h exp 55005500aaaaaaaa", d); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bid; logic [1:0] br; int lat;
    logic saw_low; logic [63:0] held;
    logic [7:0] got_id [6]; logic [63:0] got_d [6]; int at [6]; int n;
    for (int i = 0; i < 6; i++)
      do_write(8'd20, BASE + 32'h100 + 32'(i * 8), 64'hB0B0_0000_0000_0000 + 64'(i), 8'hFF, bid, br, lat);
    s_rready = 1'b0;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic sent;
          s_arvalid = 1'b1; s_arid = 8'(i); s_araddr = BASE + 32'h100 + 32'(i * 8);
          sent = 1'b0;
          for (int k = 0; k < 200 && !sent; k++) begin
            @(negedge clk);
            if (s_arready) sent = 1'b1;
            @(posedge clk); #1;
          end
        end
        s_arvalid = 1'b0;
      end
    join_none
    repeat (10) begin @(negedge clk); if (!s_arready) saw_low = 1'b1; end
    checks++; if (saw_low !== 1'b1) $display("FAIL b2b_arready_drop got %b exp 1", saw_low); else passed++;
    checks++; if (s_rvalid !== 1'b1) $display("FAIL b2b_rvalid_held got %b exp 1", s_rvalid); else passed++;
    checks++; if (s_rid !== 8'd0) $display("FAIL b2b_rid_held got %0d exp 0", s_rid); else passed++;
    held = s_rdata;
    checks++; if (held !== 64'hB0B0_0000_0000_0000) $display("FAIL b2b_data_held got %h exp b0b0000000000000", held); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (s_rdata !== 64'hB0B0_0000_0000_0000 || s_rid !== 8'd0)
      $display("FAIL b2b_stable got rid %0d data %h exp rid 0 data b0b0000000000000", s_rid, s_rdata); else passed++;
    @(posedge clk); #1;
    s_rready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      @(negedge clk);
      if (s_rvalid) begin got_id[n] = s_rid; got_d[n] = s_rdata; at[n] = cyc; n++; end
    end
    checks++; if (n !== 6) $display("FAIL b2b_beats got %0d exp 6", n); else passed++;
    for (int i = 0; i < n; i++) begin
      checks++; if (got_id[i] !== 8'(i)) $display("FAIL b2b_order beat %0d got rid %0d exp %0d", i, got_id[i], i); else passed++;
      checks++; if (got_d[i] !== 64'hB0B0_0000_0000_0000 + 64'(i))
        $display("FAIL b2b_data beat %0d got %h exp b0b00000000000%02h", i, got_d[i], i); else passed++;
    end
    if (n == 6) begin
      checks++; if (at[5] - at[0] !== 5) $display("FAIL b2b_rate got span %0d exp 5", at[5] - at[0]); else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w_before_aw();
    logic [7:0] rid; logic [1:0] rr; logic rl; logic [63:0] d; int lat, early, extra;
    s_wvalid = 1'b1; s_wdata = 64'h0F0F_1234_5678_9ABC; s_wstrb = 8'hFF;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    early = 0;
    repeat (2) begin @(negedge clk); if (s_bvalid) early++; @(posedge clk); #1; end
    s_awvalid = 1'b1; s_awid = 8'd9; s_awaddr = BASE + 32'h180;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (!s_bvalid) continue;
      lat = k;
      checks++; if (s_bid !== 8'd9 || s_bresp !== 2'b00)
        $display("FAIL wfirst_b got bid %0d bresp %b exp bid 9 bresp 00", s_bid, s_bresp); else passed++;
      break;
    end
    @(posedge clk); #1;
    checks++; if (early !== 0) $display("FAIL wfirst_early_b got %0d exp 0", early); else passed++;
    checks++; if (lat !== 3) $display("FAIL wfirst_b_latency got %0d exp 3", lat); else passed++;
    extra = 0;
    repeat (10) begin @(negedge clk); if (s_bvalid) extra++; end
    checks++; if (extra !== 0) $display("FAIL wfirst_extra_b got %0d exp 0", extra); else passed++;
    @(posedge clk); #1;
    do_read(8'd10, BASE + 32'h180, d, rid, rr, rl, lat);
    checks++; if (d !== 64'h0F0F_1234_5678_9ABC) $display("FAIL wfirst_readback got %h exp 0f0f123456789abc", d); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [7:0] bid, rid; logic [1:0] br, rr; logic rl; logic [63:0] d; int lat;
    do_write(8'd11, BASE + 32'h7_FFF8, 64'hDEAD_BEEF_0123_4567, 8'hFF, bid, br, lat);
    checks++; if (br !== 2'b00) $display("FAIL oor_top_word_bresp got %b exp 00", br); else passed++;
    do_read(8'd12, BASE - 32'h8, d, rid, rr, rl, lat);
    checks++; if (rr !== 2'b10) $display("FAIL oor_low_rresp got %b exp 10", rr); else passed++;
    checks++; if (d !== 64'd0) $display("FAIL oor_low_rdata got %h exp 0", d); else passed++;
    checks++; if (rid !== 8'd12) $display("FAIL oor_low_rid got %0d exp 12", rid); else passed++;
    do_read(8'd13, BASE + 32'h8_0000, d, rid, rr, rl, lat);
    checks++; if (rr !== 2'b10) $display("FAIL oor_high_rresp got %b exp 10", rr); else passed++;
    do_write(8'd14, BASE - 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, bid, br, lat);
    checks++; if (br !== 2'b10) $display("FAIL oor_bresp got %b exp 10", br); else passed++;
    checks++; if (bid !== 8'd14) $display("FAIL oor_bid got %0d exp 14", bid); else passed++;
    do_read(8'd15, BASE + 32'h7_FFF8, d, rid, rr, rl, lat);
    checks++; if (d !== 64'hDEAD_BEEF_0123_4567) $display("FAIL oor_mem_unchanged got %h exp deadbeef01234567", d); else passed++;
    checks++; if (rr !== 2'b00) $display("FAIL oor_top_word_rresp got %b exp 00", rr); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rid; logic [1:0] rr; logic rl; logic [63:0] d; int lat, seen, stale;
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_arid = 8'd1; s_araddr = BASE + 32'h80;
    @(posedge clk); #1;
    s_arid = 8'd2;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin @(negedge clk); if (s_rvalid) seen = 1; end
    checks++; if (seen !== 1) $display("FAIL rstmid_pending_r got %0d exp 1", seen); else passed++;
    @(posedge clk); #1;
    reset_l = 1'b0;
    @(posedge clk); #1;
    reset_l = 1'b1;
    s_rready = 1'b1;
    @(negedge clk);
    checks++; if (s_rvalid !== 1'b0) $display("FAIL rstmid_rvalid got %b exp 0", s_rvalid); else passed++;
    checks++; if (s_arready !== 1'b1) $display("FAIL rstmid_arready got %b exp 1", s_arready); else passed++;
    stale = 0;
    repeat (20) begin @(negedge clk); if (s_rvalid || s_bvalid) stale++; end
    checks++; if (stale !== 0) $display("FAIL rstmid_stale_resp got %0d exp 0", stale); else passed++;
    @(posedge clk); #1;
    repeat (300) @(posedge clk);
    #1;
    do_read(8'd6, BASE + 32'h80, d, rid, rr, rl, lat);
    checks++; if (lat !== 4) $display("FAIL wrap_latency got %0d exp 4", lat); else passed++;
    checks++; if (d !== 64'h1122_3344_5566_7788) $display("FAIL wrap_data got %h exp 1122334455667788", d); else passed++;
    checks++; if (rid !== 8'd6) $display("FAIL wrap_rid got %0d exp 6", rid); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_strobe();
    test_back_to_back();
    test_w_before_aw();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
